// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - pipelined ID/EX/MEM/WB control decode with jump-squash FSM
// Optional branch decodes (BEQ/BNE/BGTZ/BLEZ) enabled by defining BRANCH_DECODE_EN.
module pipe_control_unit #(
    parameter int CTRL_W       = 8,
    parameter int JUMP_BUBBLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              instValid,
    input  logic              stall,
    input  logic              flush,
    output logic [CTRL_W-1:0] idCtrl,
    output logic [CTRL_W-1:0] exCtrl,
    output logic [CTRL_W-1:0] memCtrl,
    output logic [CTRL_W-1:0] wbCtrl,
    output logic              isJump,
    output logic [1:0]        branchSrc,
    output logic [2:0]        compareCode,
    output logic              jumpSquash
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_BUBBLE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [7:0]  w_dec_ctrl;
    logic [1:0]  w_dec_bsrc;
    logic [2:0]  w_dec_cc;
    logic        w_dec_jump;
    logic        w_squash;

    always_comb begin
        w_dec_ctrl = 8'h00;
        w_dec_bsrc = 2'b00;
        w_dec_cc   = 3'b000;
        w_dec_jump = 1'b0;
        if (instValid) begin
            case (opcode)
                6'h00: begin
                    if (funct == 6'h08) begin
                        w_dec_bsrc = 2'b10;
                        w_dec_cc   = 3'b101;
                        w_dec_jump = 1'b1;
                    end else begin
                        w_dec_ctrl = 8'h04;
                    end
                end
                6'h02: begin
                    w_dec_bsrc = 2'b01;
                    w_dec_cc   = 3'b101;
                    w_dec_jump = 1'b1;
                end
                6'h03: begin
                    w_dec_ctrl = 8'h46;
                    w_dec_bsrc = 2'b01;
                    w_dec_cc   = 3'b101;
                    w_dec_jump = 1'b1;
                end
                6'h08, 6'h0C: w_dec_ctrl = 8'hA4;
                6'h23:        w_dec_ctrl = 8'hB5;
                6'h2B:        w_dec_ctrl = 8'h88;
`ifdef BRANCH_DECODE_EN
                // Branches redirect fetch like jumps, so they share the squash path.
                6'h04: begin w_dec_cc = 3'b001; w_dec_jump = 1'b1; end
                6'h05: begin w_dec_cc = 3'b010; w_dec_jump = 1'b1; end
                6'h07: begin w_dec_cc = 3'b011; w_dec_jump = 1'b1; end
                6'h06: begin w_dec_cc = 3'b100; w_dec_jump = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    assign jumpSquash  = (r_state == S_BUBBLE);
    assign w_squash    = jumpSquash | flush;
    assign idCtrl      = w_squash ? '0 : CTRL_W'(w_dec_ctrl);
    assign isJump      = ~w_squash & w_dec_jump;
    assign branchSrc   = w_squash ? 2'b00 : w_dec_bsrc;
    assign compareCode = w_squash ? 3'b000 : w_dec_cc;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
        end else if (!stall) begin
            case (r_state)
                S_IDLE: begin
                    if (isJump && (JUMP_BUBBLES > 0)) begin
                        w_state_nxt = S_BUBBLE;
                        w_cnt_nxt   = 2'(JUMP_BUBBLES);
                    end
                end
                S_BUBBLE: begin
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                    w_cnt_nxt = r_cnt - 2'd1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MEM and WB always advance; only the EX entry point sees stall/flush bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            exCtrl  <= '0;
            memCtrl <= '0;
            wbCtrl  <= '0;
        end else begin
            exCtrl  <= (stall | flush) ? '0 : idCtrl;
            memCtrl <= exCtrl;
            wbCtrl  <= memCtrl;
        end
    end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed table plus randomized model check of pipe_control_unit
module tb_pipe_control_unit;

    localparam int CTRL_W = 10;
    localparam int JB     = 2;

`ifdef BRANCH_DECODE_EN
    localparam logic       BR_J  = 1'b1;
    localparam logic [2:0] BR_CC = 3'b010;
`else
    localparam logic       BR_J  = 1'b0;
    localparam logic [2:0] BR_CC = 3'b000;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [5:0]        opcode, funct;
    logic              instValid, stall, flush;
    logic [CTRL_W-1:0] idCtrl, exCtrl, memCtrl, wbCtrl;
    logic              isJump, jumpSquash;
    logic [1:0]        branchSrc;
    logic [2:0]        compareCode;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_control_unit #(.CTRL_W(CTRL_W), .JUMP_BUBBLES(JB)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .instValid(instValid), .stall(stall), .flush(flush),
        .idCtrl(idCtrl), .exCtrl(exCtrl), .memCtrl(memCtrl), .wbCtrl(wbCtrl),
        .isJump(isJump), .branchSrc(branchSrc), .compareCode(compareCode),
        .jumpSquash(jumpSquash)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       v, st, fl;
        logic [7:0] id, ex, mem, wb;
        logic       js, jmp;
        logic [1:0] bs;
        logic [2:0] cc;
    } vec_t;

    typedef struct {
        logic [7:0] ctrl;
        logic [1:0] bs;
        logic [2:0] cc;
        logic       jmp;
    } dec_t;

    vec_t tbl[$];

    // Reference state: pipeline contents and number of squash slots still owed.
    logic [7:0] m_ex = 8'h00, m_mem = 8'h00, m_wb = 8'h00;
    int         m_left = 0;

    function automatic vec_t mk(logic rst, logic [5:0] op, logic [5:0] fn, logic v, logic st,
                                logic fl, logic [7:0] id, logic [7:0] ex, logic [7:0] mem,
                                logic [7:0] wb, logic js, logic jmp, logic [1:0] bs,
                                logic [2:0] cc);
        vec_t r;
        r.rst = rst; r.op = op; r.fn = fn; r.v = v; r.st = st; r.fl = fl;
        r.id = id; r.ex = ex; r.mem = mem; r.wb = wb; r.js = js; r.jmp = jmp;
        r.bs = bs; r.cc = cc;
        return r;
    endfunction

    function automatic dec_t m_decode(logic [5:0] op, logic [5:0] fn, logic v);
        dec_t d;
        d = '{ctrl: 8'h00, bs: 2'b00, cc: 3'b000, jmp: 1'b0};
        if (v) begin
            if (op == 6'h00 && fn == 6'h08) d = '{8'h00, 2'b10, 3'b101, 1'b1};
            else if (op == 6'h00)            d.ctrl = 8'h04;
            else if (op == 6'h02)            d = '{8'h00, 2'b01, 3'b101, 1'b1};
            else if (op == 6'h03)            d = '{8'h46, 2'b01, 3'b101, 1'b1};
            else if (op == 6'h08 || op == 6'h0C) d.ctrl = 8'hA4;
            else if (op == 6'h23)            d.ctrl = 8'hB5;
            else if (op == 6'h2B)            d.ctrl = 8'h88;
`ifdef BRANCH_DECODE_EN
            else if (op == 6'h04)            d = '{8'h00, 2'b00, 3'b001, 1'b1};
            else if (op == 6'h05)            d = '{8'h00, 2'b00, 3'b010, 1'b1};
            else if (op == 6'h07)            d = '{8'h00, 2'b00, 3'b011, 1'b1};
            else if (op == 6'h06)            d = '{8'h00, 2'b00, 3'b100, 1'b1};
`endif
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic v, input logic st, input logic fl);
        reset = rst; opcode = op; funct = fn; instValid = v; stall = st; flush = fl;
    endtask

    task automatic check_all(input string tag, input logic [7:0] id, input logic [7:0] ex,
                             input logic [7:0] mem, input logic [7:0] wb, input logic js,
                             input logic jmp, input logic [1:0] bs, input logic [2:0] cc);
        chk({tag, ".idCtrl"},      32'(idCtrl),      32'(id));
        chk({tag, ".exCtrl"},      32'(exCtrl),      32'(ex));
        chk({tag, ".memCtrl"},     32'(memCtrl),     32'(mem));
        chk({tag, ".wbCtrl"},      32'(wbCtrl),      32'(wb));
        chk({tag, ".jumpSquash"},  32'(jumpSquash),  32'(js));
        chk({tag, ".isJump"},      32'(isJump),      32'(jmp));
        chk({tag, ".branchSrc"},   32'(branchSrc),   32'(bs));
        chk({tag, ".compareCode"}, 32'(compareCode), 32'(cc));
    endtask

    // Advance the reference across one clock edge using the inputs currently applied.
    task automatic model_edge();
        dec_t d;
        logic squashed;
        logic [7:0] id_now;
        d        = m_decode(opcode, funct, instValid);
        squashed = (m_left > 0) || flush;
        id_now   = squashed ? 8'h00 : d.ctrl;
        if (reset) begin
            m_ex = 0; m_mem = 0; m_wb = 0; m_left = 0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (stall || flush) ? 8'h00 : id_now;
            if (flush)               m_left = 0;
            else if (stall)          m_left = m_left;
            else if (m_left > 0)     m_left = m_left - 1;
            else if (d.jmp)          m_left = JB;
        end
    endtask

    task automatic model_check(input int cyc);
        dec_t d;
        logic squashed;
        string tag;
        d        = m_decode(opcode, funct, instValid);
        squashed = (m_left > 0) || flush;
        tag      = $sformatf("rnd%0d", cyc);
        check_all(tag, squashed ? 8'h00 : d.ctrl, m_ex, m_mem, m_wb, m_left > 0,
                  !squashed && d.jmp, squashed ? 2'b00 : d.bs, squashed ? 3'b000 : d.cc);
    endtask

    initial begin
        logic [5:0] ops [12];
        ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h23, 6'h2B,
                6'h04, 6'h05, 6'h06, 6'h07, 6'h11};

        tbl.push_back(mk(1, 6'h23, 0, 1, 0, 0, 8'hB5, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h23, 0, 1, 0, 0, 8'hB5, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'hB5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'hB5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hB5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h08, 0, 1, 0, 0, 8'hA4, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h0C, 0, 1, 1, 0, 8'hA4, 8'hA4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h0C, 0, 1, 0, 0, 8'hA4, 0, 8'hA4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'hA4, 0, 8'hA4, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h03, 0, 1, 0, 0, 8'h46, 0, 8'hA4, 0, 0, 1, 2'b01, 3'b101));
        tbl.push_back(mk(0, 6'h08, 0, 1, 0, 0, 0, 8'h46, 0, 8'hA4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 6'h20, 1, 0, 0, 0, 0, 8'h46, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h2B, 0, 1, 0, 0, 8'h88, 0, 0, 8'h46, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h88, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h02, 0, 1, 0, 0, 0, 0, 8'h88, 0, 0, 1, 2'b01, 3'b101));
        tbl.push_back(mk(0, 6'h00, 6'h08, 1, 0, 0, 0, 0, 0, 8'h88, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 6'h08, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 6'h08, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b101));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h02, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 3'b101));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h03, 0, 1, 1, 0, 8'h46, 0, 0, 0, 0, 1, 2'b01, 3'b101));
        tbl.push_back(mk(0, 6'h03, 0, 1, 0, 0, 8'h46, 0, 0, 0, 0, 1, 2'b01, 3'b101));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h46, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h46, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h46, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h02, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h05, 0, 1, 0, 0, 0, 0, 0, 0, 0, BR_J, 0, BR_CC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BR_J, 0, 0, 0));

        drive(1, 0, 0, 0, 0, 0);
        @(posedge clock);
        model_edge();
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].v, tbl[i].st, tbl[i].fl);
            @(negedge clock);
            check_all($sformatf("row%0d", i), tbl[i].id, tbl[i].ex, tbl[i].mem, tbl[i].wb,
                      tbl[i].js, tbl[i].jmp, tbl[i].bs, tbl[i].cc);
            @(posedge clock);
            model_edge();
            #1;
        end

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 49) == 0),
                  ops[$urandom_range(0, 11)],
                  ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 11) == 0));
            @(negedge clock);
            model_check(c);
            @(posedge clock);
            model_edge();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Parametrised, pipelined successor to the combinational mips32 decoder.
- Decodes opcode/funct in ID, then carries the control word through registered ID/EX, EX/MEM and MEM/WB stages.
- Supports stall (bubble) and flush (squash).
- A jump-squash FSM inserts a configurable number of NOP slots after each jump. Sits between the IF/ID register and the datapath stage registers.

Parameters:
- CTRL_W, 8, control word width; must be >= 8; bits [CTRL_W-1:8] always 0.
- JUMP_BUBBLES, 1, instructions squashed after a jump decode; legal range 0..3.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction [31:26]
- funct  in  6  instruction [5:0]
- instValid  in  1  ID holds a real instruction
- stall  in  1  hazard unit: freeze ID, bubble into EX
- flush  in  1  squash the ID instruction and clear the jump FSM
- idCtrl  out  CTRL_W  combinational decode after squash masking
- exCtrl  out  CTRL_W  registered EX-stage control
- memCtrl  out  CTRL_W  registered MEM-stage control
- wbCtrl  out  CTRL_W  registered WB-stage control
- isJump  out  1  combinational; ID holds a non-squashed J/JAL/JR
- branchSrc  out  2  00 pc+4+imm, 01 imm26, 10 rs
- compareCode  out  3  000 none, 001 beq, 010 bne, 011 bgt, 100 ble, 101 jump
- jumpSquash  out  1  registered; FSM in BUBBLE state

Behaviour:
- Control word bit map:
  - [7] AluSrc: 1 = immediate.
  - [6:5] RegDest: 00 rd, 01 rt, 10 $ra.
  - [4] MemRead.
  - [3] MemWrite.
  - [2] RegWrite.
  - [1:0] RegSrc: 00 ALU, 01 mem, 10 pc+4.
- Decode table: opcode hex -> ctrl, branchSrc, compareCode.
  - 00 with funct 08 (JR) -> 00, 10, 101.
  - 00 with any other funct -> 04, 00, 000.
  - 02 (J) -> 00, 01, 101.
  - 03 (JAL) -> 46, 01, 101.
  - 08 (ADDI) -> A4, 00, 000.
  - 0C (ANDI) -> A4, 00, 000.
  - 23 (LW) -> B5, 00, 000.
  - 2B (SW) -> 88, 00, 000.
  - Any other opcode, X/Z inputs, or instValid=0 -> all outputs 0.
- Squash masking: when jumpSquash=1 or flush=1, idCtrl, isJump, branchSrc and compareCode are forced to 0.
- Stage update on each clock with reset=0:
  - memCtrl <= exCtrl and wbCtrl <= memCtrl, always, regardless of stall.
  - exCtrl <= 0 if (stall | flush); otherwise exCtrl <= idCtrl.
  - Latency ID -> WB is 3 cycles.
- Simultaneous stall and flush: flush wins for the FSM; exCtrl is 0 either way.
- Jump FSM, states IDLE and BUBBLE, with counter cnt of width 2:
  - IDLE -> BUBBLE when isJump & !stall & JUMP_BUBBLES>0; cnt loads JUMP_BUBBLES.
  - In BUBBLE, a non-stall cycle with cnt==1 goes to IDLE; otherwise cnt decrements.
  - stall freezes cnt and state.
  - flush forces IDLE (cnt=0) from either state, taking priority over a jump in the same cycle.
  - A jump presented in BUBBLE is squashed, so it does not retrigger the FSM.
  - With JUMP_BUBBLES=0 the FSM never leaves IDLE.
- A jump under stall is held in ID; the FSM triggers on the first non-stall cycle.
- Reset (also valid mid-operation): exCtrl, memCtrl and wbCtrl go to 0, the FSM to IDLE, cnt to 0 and jumpSquash to 0, all on the same edge. Combinational outputs follow the inputs immediately.

Optional Feature:
- Macro BRANCH_DECODE_EN.
- When defined, additional decodes (branchSrc 00, ctrl 00):
  - 04 (BEQ) -> compareCode 001.
  - 05 (BNE) -> 010.
  - 07 (BGTZ) -> 011.
  - 06 (BLEZ) -> 100.
- When defined, branches also behave like jumps: they assert isJump and trigger the squash FSM.
- When undefined, these opcodes decode as unknown (all zero) and never touch the FSM.

Test Plan:
- Reset held 2 cycles, then LW (op 23) with instValid=1 and no stall -> idCtrl=B5 same cycle; exCtrl=B5 after 1 clock, memCtrl after 2, wbCtrl after 3; all 0 during reset.
- ADDI, then stall=1 for 1 cycle, then ANDI -> exCtrl sequence A4, 00, A4. ID holds ANDI during the stall; memCtrl/wbCtrl keep advancing.
- JAL with JUMP_BUBBLES=2, followed by ADDI, R-type, SW -> isJump=1, compareCode=101, branchSrc=01. jumpSquash=1 for exactly 2 cycles and both followers give exCtrl=00. SW then passes with exCtrl=88.
- JR (op 00, funct 08) in BUBBLE -> isJump=0 and the FSM is not retriggered. The same JR in IDLE -> branchSrc=10, compareCode=101.
- Jump then flush=1 in the first BUBBLE cycle -> FSM returns to IDLE next edge and jumpSquash=0. Reset asserted mid-BUBBLE also clears everything on that edge.
- With BRANCH_DECODE_EN, op 05 -> compareCode=010 and squash triggers. Without it, op 05 -> all zero and jumpSquash stays 0.
